// File: rtl/ring_counter_pkg.sv
// Shared types and constants for the ring/Johnson shift-register counter.
// The seed helper gives the one-hot "bit 0 set" start state for any width.
package ring_counter_pkg;

  typedef enum logic {
    MODE_RING    = 1'b0,
    MODE_JOHNSON = 1'b1
  } mode_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int MAX_WIDTH = 64;

  // Callers truncate the result to their own width.
  function automatic logic [MAX_WIDTH-1:0] seedValue(input int width);
    logic [MAX_WIDTH-1:0] seed;
    seed = '0;
    if (width > 0) seed[0] = 1'b1;
    return seed;
  endfunction

endpackage

// File: rtl/ring_state_check.sv
// Combinational legality check of a counter state for ring or Johnson mode.
// Ring needs exactly one bit set; Johnson allows at most one adjacent-bit change.
module ring_state_check
  import ring_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic             mode,
  output logic             legal
);

  logic [WIDTH-2:0] w_edges;
  int               w_onesCount;
  int               w_edgeCount;

  assign w_edges     = q[WIDTH-2:0] ^ q[WIDTH-1:1];
  assign w_onesCount = $countones(q);
  assign w_edgeCount = $countones(w_edges);

  always_comb begin
    legal = 1'b0;
    if (mode == MODE_JOHNSON) legal = (w_edgeCount <= 1);
    else                      legal = (w_onesCount == 1);
  end

endmodule

// File: rtl/ring_johnson_counter.sv
// Parametrised ring / Johnson counter with direction, enable, parallel load,
// illegal-state recovery to SEED, a registered wrap strobe and a sticky error flag.
module ring_johnson_counter
  import ring_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             err
);

  localparam logic [WIDTH-1:0] SEED = WIDTH'(seedValue(WIDTH));

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             r_err;
  logic [WIDTH-1:0] w_stepQ;
  logic             w_legal;

  ring_state_check #(.WIDTH(WIDTH)) u_check (
    .q     (r_q),
    .mode  (mode),
    .legal (w_legal)
  );

  always_comb begin
    w_stepQ = r_q;
    case ({mode, dir})
      {MODE_RING,    DIR_LEFT }: w_stepQ = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      {MODE_RING,    DIR_RIGHT}: w_stepQ = {r_q[0], r_q[WIDTH-1:1]};
      {MODE_JOHNSON, DIR_LEFT }: w_stepQ = {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
      {MODE_JOHNSON, DIR_RIGHT}: w_stepQ = {~r_q[0], r_q[WIDTH-1:1]};
      default:                   w_stepQ = r_q;
    endcase
  end

  // Load beats step; an illegal state on an enabled step snaps back to SEED and latches err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q    <= SEED;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else if (load) begin
      r_q    <= load_val;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else if (en) begin
      if (w_legal) begin
        r_q    <= w_stepQ;
        r_wrap <= (w_stepQ == SEED);
      end else begin
        r_q    <= SEED;
        r_wrap <= 1'b0;
        r_err  <= 1'b1;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign q    = r_q;
  assign wrap = r_wrap;
  assign err  = r_err;

endmodule

// File: tb/tb_ring_johnson_counter.sv
// Directed self-checking bench: a 4-bit and an 8-bit counter driven by one clock.
// Inputs change on the falling edge; outputs are checked on the following falling edge.
module tb_ring_johnson_counter;
  import ring_counter_pkg::*;

  logic       clk = 1'b0;
  logic       rstA, enA, modeA, dirA, loadA;
  logic [3:0] loadValA, qA;
  logic       wrapA, errA;
  logic       rstB, enB, modeB, dirB, loadB;
  logic [7:0] loadValB, qB;
  logic       wrapB, errB;

  int total = 0;
  int bad   = 0;

  logic [3:0] ringLeftQ   [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] ringRightQ  [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
  logic [3:0] johnsonQ    [9] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110,
                                  4'b1100, 4'b1000, 4'b0000, 4'b0001};
  logic       johnsonWrap [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [7:0] wideQ       [4] = '{8'h20, 8'h40, 8'h80, 8'h01};

  always #5 clk = ~clk;

  ring_johnson_counter #(.WIDTH(4)) dutA (
    .clk(clk), .rst(rstA), .en(enA), .mode(modeA), .dir(dirA),
    .load(loadA), .load_val(loadValA), .q(qA), .wrap(wrapA), .err(errA)
  );

  ring_johnson_counter #(.WIDTH(8)) dutB (
    .clk(clk), .rst(rstB), .en(enB), .mode(modeB), .dir(dirB),
    .load(loadB), .load_val(loadValB), .q(qB), .wrap(wrapB), .err(errB)
  );

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic load, input logic mode,
                               input logic dir, input logic [3:0] loadVal);
    enA      = en;
    loadA    = load;
    modeA    = mode;
    dirA     = dir;
    loadValA = loadVal;
    @(negedge clk);
  endtask

  initial begin
    rstA = 1'b0; enA = 1'b0; modeA = MODE_RING; dirA = DIR_LEFT; loadA = 1'b0; loadValA = '0;
    rstB = 1'b0; enB = 1'b0; modeB = MODE_RING; dirB = DIR_LEFT; loadB = 1'b0; loadValB = '0;
    @(negedge clk);
    @(negedge clk);
    rstA = 1'b1;
    rstB = 1'b1;
    checkOutput("resetQ", {4'b0, qA}, 8'h01);
    checkOutput("resetWrap", {7'b0, wrapA}, 8'h00);
    checkOutput("resetErr", {7'b0, errA}, 8'h00);

    // Move off SEED, then pull reset between edges and look before the next edge.
    applyStimulus(1'b1, 1'b0, MODE_RING, DIR_LEFT, 4'b0000);
    checkOutput("firstStep", {4'b0, qA}, 8'h02);
    enA = 1'b0;
    #2 rstA = 1'b0;
    #1;
    checkOutput("asyncResetQ", {4'b0, qA}, 8'h01);
    checkOutput("asyncResetWrap", {7'b0, wrapA}, 8'h00);
    checkOutput("asyncResetErr", {7'b0, errA}, 8'h00);
    @(negedge clk);
    rstA = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, MODE_RING, DIR_LEFT, 4'b0000);
      checkOutput("holdQ", {4'b0, qA}, 8'h01);
    end

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, MODE_RING, DIR_LEFT, 4'b0000);
      checkOutput("ringLeftQ", {4'b0, qA}, {4'b0, ringLeftQ[i]});
      checkOutput("ringLeftWrap", {7'b0, wrapA}, {7'b0, (i == 3)});
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, MODE_RING, DIR_RIGHT, 4'b0000);
      checkOutput("ringRightQ", {4'b0, qA}, {4'b0, ringRightQ[i]});
      checkOutput("ringRightWrap", {7'b0, wrapA}, {7'b0, (i == 3)});
    end
    applyStimulus(1'b0, 1'b0, MODE_RING, DIR_RIGHT, 4'b0000);
    checkOutput("wrapDrops", {7'b0, wrapA}, 8'h00);
    checkOutput("idleHoldQ", {4'b0, qA}, 8'h01);

    applyStimulus(1'b0, 1'b1, MODE_JOHNSON, DIR_LEFT, 4'b0000);
    checkOutput("johnsonLoadQ", {4'b0, qA}, 8'h00);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 1'b0, MODE_JOHNSON, DIR_LEFT, 4'b0000);
      checkOutput("johnsonQ", {4'b0, qA}, {4'b0, johnsonQ[i]});
      checkOutput("johnsonWrap", {7'b0, wrapA}, {7'b0, johnsonWrap[i]});
      checkOutput("johnsonErr", {7'b0, errA}, 8'h00);
    end

    applyStimulus(1'b0, 1'b1, MODE_RING, DIR_LEFT, 4'b0101);
    checkOutput("illegalLoadQ", {4'b0, qA}, 8'h05);
    checkOutput("illegalLoadErr", {7'b0, errA}, 8'h00);
    applyStimulus(1'b1, 1'b0, MODE_RING, DIR_LEFT, 4'b0000);
    checkOutput("recoverQ", {4'b0, qA}, 8'h01);
    checkOutput("recoverErr", {7'b0, errA}, 8'h01);
    checkOutput("recoverWrap", {7'b0, wrapA}, 8'h00);
    applyStimulus(1'b1, 1'b0, MODE_RING, DIR_LEFT, 4'b0000);
    checkOutput("stickyQ", {4'b0, qA}, 8'h02);
    checkOutput("stickyErr", {7'b0, errA}, 8'h01);
    applyStimulus(1'b0, 1'b0, MODE_RING, DIR_LEFT, 4'b0000);
    checkOutput("stickyIdleErr", {7'b0, errA}, 8'h01);
    applyStimulus(1'b0, 1'b1, MODE_RING, DIR_LEFT, 4'b0001);
    checkOutput("loadClearsErr", {7'b0, errA}, 8'h00);

    // Reach Johnson 0011, then flip to ring: 0011 has two bits set.
    applyStimulus(1'b1, 1'b0, MODE_JOHNSON, DIR_LEFT, 4'b0000);
    checkOutput("switchPrepQ", {4'b0, qA}, 8'h03);
    applyStimulus(1'b1, 1'b0, MODE_RING, DIR_LEFT, 4'b0000);
    checkOutput("modeSwitchQ", {4'b0, qA}, 8'h01);
    checkOutput("modeSwitchErr", {7'b0, errA}, 8'h01);
    checkOutput("modeSwitchWrap", {7'b0, wrapA}, 8'h00);
    enA = 1'b0;

    enB = 1'b1; loadB = 1'b1; loadValB = 8'h10; modeB = MODE_RING; dirB = DIR_LEFT;
    @(negedge clk);
    checkOutput("wideLoadBeatsEn", qB, 8'h10);
    loadB = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("wideQ", qB, wideQ[i]);
      checkOutput("wideWrap", {7'b0, wrapB}, {7'b0, (i == 3)});
    end
    enB = 1'b0;
    #2 rstB = 1'b0;
    #1;
    checkOutput("wideResetQ", qB, 8'h01);
    checkOutput("wideResetWrap", {7'b0, wrapB}, 8'h00);
    checkOutput("wideResetErr", {7'b0, errB}, 8'h00);
    @(negedge clk);
    rstB = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ring_johnson_counter.md
# ring_johnson_counter

Parametrised shift-register counter. It supports ring (one-hot) and Johnson (twisted-ring) sequences, both rotation directions, enable, parallel load and illegal-state self-correction. It is the general-purpose successor to the fixed 4-bit ring counter. Its uses are sequencing, phase generation and timing strobes in the day-to-day designs. It provides a registered wrap strobe and a sticky error flag for downstream logic.

## Interface
- WIDTH, 4: counter width in bits; legal range is WIDTH >= 2.
- clk  in  1  rising-edge clock; the block's only clock.
- rst  in  1  asynchronous, active-low reset; rst=0 resets immediately.
- en  in  1  step enable; takes effect on a clk edge.
- mode  in  1  0 = ring, 1 = Johnson.
- dir  in  1  0 = rotate left (toward MSB), 1 = rotate right.
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  value to load.
- q  out  WIDTH  counter state.
- wrap  out  1  one-cycle pulse on period completion.
- err  out  1  sticky illegal-state flag.

## Operation
- Seed state: SEED = 1, i.e. only bit 0 set. SEED is legal in both modes.
- Priority on each rising edge: reset > load > en > hold.
- load=1:
  - q <= load_val, accepted verbatim even if illegal.
  - err <= 0, wrap <= 0.
- en=1, load=0, q legal for the current mode: step q as follows.
  - Ring, left: q <= {q[W-2:0], q[W-1]}.
  - Ring, right: q <= {q[0], q[W-1:1]}.
  - Johnson, left: q <= {q[W-2:0], ~q[W-1]}.
  - Johnson, right: q <= {~q[0], q[W-1:1]}.
- en=1, load=0, q illegal for the current mode (recovery): q <= SEED, err <= 1, wrap <= 0.
- en=0, load=0: q and err hold; wrap <= 0.
- Legality rules:
  - Ring: exactly one bit of q is set.
  - Johnson: at most one index i in [0, W-2] has q[i] != q[i+1], i.e. the ones form a contiguous run anchored at one end.
- Legality is evaluated against the mode value sampled on the same edge. A mode change that leaves q illegal therefore triggers recovery on the next enabled step.
- wrap <= 1 for exactly one cycle when a legal, enabled step produces q == SEED. Loads and recoveries never assert wrap.
- Period lengths: ring W steps; Johnson 2W steps.
- err is cleared only by reset or load.
- dir may change on any cycle; it applies to the next step with no penalty.

## Timing
- All outputs are registered and change only on the rising edge of clk, except on reset.
- Reset (rst=0) acts asynchronously: q = SEED, wrap = 0, err = 0 immediately, held while rst=0.
- Reset release: the first step occurs on the first rising edge with rst=1 and en=1. There is no dead cycle.
- Latency from en/load to q is one edge. wrap and err are coincident with the q update that caused them.
- Reset asserted mid-period aborts the sequence; a wrap pulse in flight is cleared.
- load and en asserted together: load wins and no step occurs.

## Structure
- Package ring_counter_pkg holds:
  - the mode enum (MODE_RING=1'b0, MODE_JOHNSON=1'b1);
  - the direction constants (DIR_LEFT=1'b0, DIR_RIGHT=1'b1);
  - the SEED function of width.
- One combinational sub-module, ring_state_check (parameter WIDTH; inputs q and mode; output legal), contains both legality rules.
- The top level holds the q/wrap/err registers and the next-state mux.

## Test plan
- Reset/hold, W=4:
  - Assert rst=0 mid-clock: q=0001, wrap=0, err=0 before the next edge.
  - Release rst with en=0 for 3 edges: q stays 0001.
- Ring left, W=4, en=1: q steps 0010, 0100, 1000, 0001. wrap=1 only with the 0001 update (4th edge).
  - Ring right from 0001 steps 1000, 0100, 0010, 0001.
- Johnson left, W=4, from load 0000: q steps 0001 (wrap), 0011, 0111, 1111, 1110, 1100, 1000, 0000, 0001 (wrap). Period is 8.
- Illegal load, ring, W=4:
  - load_val=0101: q=0101, err=0.
  - Next en edge: q=0001, err=1, wrap=0.
  - err stays 1 through further steps until load.
- Mode switch: in Johnson at q=0011, set mode=1'b0 (ring). Next en edge: q=0001, err=1.
- Priority/width: W=8, load=1 with en=1 and load_val=8'h10: q=8'h10 (no step).
  - 4 left ring steps give q=8'h01 with wrap=1.
  - Asserting rst=0 mid-sequence gives q=8'h01, wrap=0 immediately.
